card_entry_ctrl: RTL and testbench

Keypad credential-entry sequencer that sits directly upstream of the ATM core and its authentication lookup. It collects a 4-digit decimal account number and a 1-digit PIN from a keypad strobe interface, presents them as stable `acc_number`/`pin` words, and samples the returned authentication result. It tracks the session lifetime, with optional inactivity timeout and lockout after repeated failures, and drives the ATM `exit` input.

---
 rtl/card_entry_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_card_entry_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_entry_ctrl.sv
// Keypad credential-entry sequencer: collects a 4-digit account and 1-digit PIN, runs the
// 2-cycle auth check, tracks the session and lockout. Define ENTRY_TIMEOUT_EN for the idle timeout.
module card_entry_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 5000,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_ok,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    output logic        cred_valid,
    output logic        session,
    output logic        atm_exit,
    output logic        entry_err,
    output logic        auth_fail,
    output logic        locked,
    output logic [2:0]  digit_cnt,
    output logic [2:0]  fsm_state
);
    typedef enum logic [2:0] {ST_ACC, ST_PIN, ST_CHECK, ST_SESSION, ST_LOCKED} state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [2:0] TRIES = 3'(MAX_TRIES);

    state_t            state, state_nxt;
    logic [13:0]       acc_acc, acc_acc_nxt;
    logic [3:0]        pin_acc, pin_acc_nxt;
    logic [2:0]        digit_cnt_nxt;
    logic [2:0]        fail_cnt, fail_cnt_nxt;
    logic [11:0]       acc_number_nxt;
    logic [3:0]        pin_nxt;
    logic              check_second, check_second_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic              atm_exit_nxt, entry_err_nxt, auth_fail_nxt;
    logic              is_digit;
    logic              expire;

    assign is_digit   = (key_code <= 4'd9);
    assign cred_valid = (state == ST_CHECK) || (state == ST_SESSION);
    assign session    = (state == ST_SESSION);
    assign locked     = (state == ST_LOCKED);
    assign fsm_state  = state;

`ifdef ENTRY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_run;

    // Counter holds its value through CHECK and LOCKED; an empty ACC keeps it at zero.
    assign idle_run = (state == ST_PIN) || (state == ST_SESSION) ||
                      ((state == ST_ACC) && (digit_cnt != 3'd0));
    assign expire   = idle_run && !key_valid && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if ((idle_run && key_valid) || expire || ((state == ST_ACC) && (digit_cnt == 3'd0)))
            idle_cnt <= '0;
        else if (idle_run)
            idle_cnt <= idle_cnt + IDLE_W'(1);
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ACC;
            acc_acc      <= '0;
            pin_acc      <= '0;
            digit_cnt    <= '0;
            fail_cnt     <= '0;
            acc_number   <= '0;
            pin          <= '0;
            check_second <= 1'b0;
            lock_cnt     <= '0;
            atm_exit     <= 1'b0;
            entry_err    <= 1'b0;
            auth_fail    <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc_acc      <= acc_acc_nxt;
            pin_acc      <= pin_acc_nxt;
            digit_cnt    <= digit_cnt_nxt;
            fail_cnt     <= fail_cnt_nxt;
            acc_number   <= acc_number_nxt;
            pin          <= pin_nxt;
            check_second <= check_second_nxt;
            lock_cnt     <= lock_cnt_nxt;
            atm_exit     <= atm_exit_nxt;
            entry_err    <= entry_err_nxt;
            auth_fail    <= auth_fail_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        acc_acc_nxt      = acc_acc;
        pin_acc_nxt      = pin_acc;
        digit_cnt_nxt    = digit_cnt;
        fail_cnt_nxt     = fail_cnt;
        acc_number_nxt   = acc_number;
        pin_nxt          = pin;
        check_second_nxt = 1'b0;
        lock_cnt_nxt     = lock_cnt;
        atm_exit_nxt     = 1'b0;
        entry_err_nxt    = 1'b0;
        auth_fail_nxt    = 1'b0;

        case (state)
            ST_ACC: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (digit_cnt < 3'd4) begin
                            acc_acc_nxt   = acc_acc * 14'd10 + {10'd0, key_code};
                            digit_cnt_nxt = digit_cnt + 3'd1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        // Only a full 4-digit number that fits the 12-bit account word is accepted.
                        if ((digit_cnt == 3'd4) && (acc_acc <= 14'd4095)) begin
                            state_nxt     = ST_PIN;
                            digit_cnt_nxt = 3'd0;
                        end else begin
                            entry_err_nxt = 1'b1;
                            acc_acc_nxt   = '0;
                            digit_cnt_nxt = 3'd0;
                        end
                    end else if ((key_code == KEY_CLEAR) || (key_code == KEY_CANCEL)) begin
                        acc_acc_nxt   = '0;
                        digit_cnt_nxt = 3'd0;
                    end
                end
            end
            ST_PIN: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (digit_cnt == 3'd0) begin
                            pin_acc_nxt   = key_code;
                            digit_cnt_nxt = 3'd1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (digit_cnt == 3'd1) begin
                            state_nxt      = ST_CHECK;
                            acc_number_nxt = acc_acc[11:0];
                            pin_nxt        = pin_acc;
                            acc_acc_nxt    = '0;
                            pin_acc_nxt    = '0;
                        end else begin
                            entry_err_nxt = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        pin_acc_nxt   = '0;
                        digit_cnt_nxt = 3'd0;
                    end else if (key_code == KEY_CANCEL) begin
                        state_nxt     = ST_ACC;
                        acc_acc_nxt   = '0;
                        pin_acc_nxt   = '0;
                        digit_cnt_nxt = 3'd0;
                    end
                end
            end
            ST_CHECK: begin
                if (!check_second) begin
                    check_second_nxt = 1'b1;
                end else begin
                    digit_cnt_nxt = 3'd0;
                    if (auth_ok) begin
                        state_nxt    = ST_SESSION;
                        fail_cnt_nxt = 3'd0;
                    end else begin
                        auth_fail_nxt  = 1'b1;
                        fail_cnt_nxt   = fail_cnt + 3'd1;
                        acc_number_nxt = '0;
                        pin_nxt        = '0;
                        if (fail_cnt + 3'd1 == TRIES) begin
                            state_nxt    = ST_LOCKED;
                            lock_cnt_nxt = '0;
                        end else begin
                            state_nxt = ST_ACC;
                        end
                    end
                end
            end
            ST_SESSION: begin
                if (key_valid && (key_code == KEY_CANCEL)) begin
                    state_nxt      = ST_ACC;
                    atm_exit_nxt   = 1'b1;
                    acc_number_nxt = '0;
                    pin_nxt        = '0;
                    digit_cnt_nxt  = 3'd0;
                end
            end
            ST_LOCKED: begin
                if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = ST_ACC;
                    fail_cnt_nxt = 3'd0;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                end
            end
            default: state_nxt = ST_ACC;
        endcase

        // Abandoned entry or session; expiry never coincides with an accepted key.
        if (expire) begin
            state_nxt      = ST_ACC;
            acc_acc_nxt    = '0;
            pin_acc_nxt    = '0;
            digit_cnt_nxt  = 3'd0;
            acc_number_nxt = '0;
            pin_nxt        = '0;
            atm_exit_nxt   = (state == ST_SESSION);
        end
    end
endmodule

// File: tb/tb_card_entry_ctrl.sv
// Bench for card_entry_ctrl: directed scenarios plus randomized key traffic, every cycle
// compared against a behavioural model built from digit queues and cycle counters.
module tb_card_entry_ctrl;
    localparam int MAX_TRIES      = 3;
    localparam int LOCK_CYCLES    = 5000;
    localparam int TIMEOUT_CYCLES = 1000;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif
    localparam int P_ACC = 0, P_PIN = 1, P_CHECK = 2, P_SESSION = 3, P_LOCKED = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        auth_ok;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic        cred_valid, session, atm_exit, entry_err, auth_fail, locked;
    logic [2:0]  digit_cnt;
    logic [2:0]  fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int auth_mode;   // 0: auth_ok low, 1: high, 2: random every cycle
    int lock_count;

    card_entry_ctrl #(
        .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .auth_ok(auth_ok), .acc_number(acc_number), .pin(pin), .cred_valid(cred_valid),
        .session(session), .atm_exit(atm_exit), .entry_err(entry_err),
        .auth_fail(auth_fail), .locked(locked), .digit_cnt(digit_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model
    int m_phase;
    int m_digits[$];
    int m_pin_digit;
    bit m_pin_have;
    int m_acc_number, m_pin;
    int m_check_left, m_fails, m_lock_left, m_idle;
    bit m_exit, m_err, m_fail;

    function automatic int digits_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    task automatic clear_fields();
        m_digits.delete();
        m_pin_have  = 1'b0;
        m_pin_digit = 0;
    endtask

    task automatic model_reset();
        m_phase = P_ACC;
        clear_fields();
        m_acc_number = 0; m_pin = 0;
        m_check_left = 0; m_fails = 0; m_lock_left = 0; m_idle = 0;
        m_exit = 1'b0; m_err = 1'b0; m_fail = 1'b0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit ok);
        bit running, expired;
        m_exit = 1'b0; m_err = 1'b0; m_fail = 1'b0;
        running = TIMEOUT_ON && (m_phase == P_PIN || m_phase == P_SESSION ||
                                 (m_phase == P_ACC && m_digits.size() > 0));
        expired = running && !kv && (m_idle + 1 >= TIMEOUT_CYCLES);
        if (running) m_idle = (kv || expired) ? 0 : m_idle + 1;
        else if (m_phase == P_ACC) m_idle = 0;

        if (expired) begin
            if (m_phase == P_SESSION) m_exit = 1'b1;
            m_phase = P_ACC;
            clear_fields();
            m_acc_number = 0; m_pin = 0;
        end else begin
            case (m_phase)
                P_ACC: if (kv) begin
                    if (kc <= 9) begin
                        if (m_digits.size() < 4) m_digits.push_back(kc);
                    end else if (kc == 11) begin
                        if (m_digits.size() == 4 && digits_value() <= 4095) begin
                            m_phase = P_PIN; m_pin_have = 1'b0; m_pin_digit = 0;
                        end else begin
                            m_err = 1'b1; m_digits.delete();
                        end
                    end else if (kc == 10 || kc == 12) begin
                        m_digits.delete();
                    end
                end
                P_PIN: if (kv) begin
                    if (kc <= 9) begin
                        if (!m_pin_have) begin m_pin_digit = kc; m_pin_have = 1'b1; end
                    end else if (kc == 11) begin
                        if (m_pin_have) begin
                            m_phase = P_CHECK; m_check_left = 2;
                            m_acc_number = digits_value(); m_pin = m_pin_digit;
                        end else begin
                            m_err = 1'b1;
                        end
                    end else if (kc == 10) begin
                        m_pin_have = 1'b0; m_pin_digit = 0;
                    end else if (kc == 12) begin
                        m_phase = P_ACC; clear_fields();
                    end
                end
                P_CHECK: begin
                    m_check_left--;
                    if (m_check_left == 0) begin
                        clear_fields();
                        if (ok) begin
                            m_phase = P_SESSION; m_fails = 0;
                        end else begin
                            m_fail = 1'b1; m_fails++;
                            m_acc_number = 0; m_pin = 0;
                            if (m_fails == MAX_TRIES) begin
                                m_phase = P_LOCKED; m_lock_left = LOCK_CYCLES;
                            end else begin
                                m_phase = P_ACC;
                            end
                        end
                    end
                end
                P_SESSION: if (kv && kc == 12) begin
                    m_exit = 1'b1; m_acc_number = 0; m_pin = 0;
                    m_phase = P_ACC; clear_fields();
                end
                P_LOCKED: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin m_phase = P_ACC; m_fails = 0; end
                end
                default: ;
            endcase
        end
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("acc_number", acc_number, m_acc_number);
        check("pin", pin, m_pin);
        check("cred_valid", cred_valid, (m_phase == P_CHECK || m_phase == P_SESSION));
        check("session", session, (m_phase == P_SESSION));
        check("locked", locked, (m_phase == P_LOCKED));
        check("atm_exit", atm_exit, m_exit);
        check("entry_err", entry_err, m_err);
        check("auth_fail", auth_fail, m_fail);
        if (m_phase == P_ACC) check("digit_cnt_acc", digit_cnt, m_digits.size());
        else if (m_phase == P_PIN) check("digit_cnt_pin", digit_cnt, m_pin_have);
        else if (m_phase == P_LOCKED) check("digit_cnt_locked", digit_cnt, 0);
    endtask

    // Driver tasks
    task automatic step(input bit kv, input int kc);
        bit ok;
        ok = (auth_mode == 2) ? 1'($urandom_range(0, 1)) : (auth_mode == 1);
        key_valid = kv;
        key_code  = 4'(kc);
        auth_ok   = ok;
        model_step(kv, kc, ok);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic press(input int kc);
        step(1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 15)));
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++) step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
    endtask

    task automatic enter_creds(input int value, input int p);
        press(value / 1000 % 10);
        press(value / 100 % 10);
        press(value / 10 % 10);
        press(value % 10);
        press(11);
        press(p);
        press(11);
    endtask

    task automatic go_idle();
        for (int i = 0; i < LOCK_CYCLES + 10 && (m_phase == P_LOCKED || m_phase == P_CHECK); i++)
            step(1'b0, 0);
        press(12);
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; auth_ok = 1'b0; auth_mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        check("reset_digit_cnt", digit_cnt, 0);
        rst_n = 1'b1;
        idle(2);

        // Successful login, then session keys
        auth_mode = 1;
        enter_creds(2749, 0);
        check("login_cred_valid", cred_valid, 1);
        check("login_not_yet_session", session, 0);
        step(1'b0, 0);
        step(1'b0, 0);
        check("login_session", session, 1);
        check("login_acc", acc_number, 2749);
        check("login_pin", pin, 0);
        press(3);
        check("session_key3", session, 1);
        press(12);
        check("cancel_exit", atm_exit, 1);
        check("cancel_acc", acc_number, 0);
        check("cancel_session", session, 0);
        step(1'b0, 0);
        check("exit_single", atm_exit, 0);

        // Rejected account entries
        press(5); press(0); press(0); press(0); press(11);
        check("big_acc_err", entry_err, 1);
        check("big_acc_cnt", digit_cnt, 0);
        press(1); press(2); press(11);
        check("short_acc_err", entry_err, 1);
        press(11);
        check("empty_acc_err", entry_err, 1);

        // Lockout after three failures
        auth_mode = 0;
        for (int t = 0; t < MAX_TRIES; t++) begin
            enter_creds(2175, 5);
            step(1'b0, 0);
            step(1'b0, 0);
            check("lock_auth_fail", auth_fail, 1);
        end
        check("locked_now", locked, 1);
        lock_count = 1;
        for (int i = 0; i < LOCK_CYCLES + 10 && locked; i++) begin
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
            if (locked) lock_count++;
        end
        check("lock_dwell", lock_count, LOCK_CYCLES);
        check("unlocked", locked, 0);

        // Reset in the first CHECK cycle clears the failure count
        go_idle();
        for (int t = 0; t < MAX_TRIES - 1; t++) begin
            enter_creds(2175, 5);
            step(1'b0, 0);
            step(1'b0, 0);
        end
        enter_creds(1234, 7);
        check("pre_rst_cred_valid", cred_valid, 1);
        rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        check("rst_cred_valid", cred_valid, 0);
        check("rst_acc", acc_number, 0);
        check("rst_pin", pin, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_auth_fail", auth_fail, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_outputs();
        enter_creds(2175, 5);
        step(1'b0, 0);
        step(1'b0, 0);
        check("post_rst_fail", auth_fail, 1);
        check("post_rst_not_locked", locked, 0);

        // Idle timeout behaviour
        auth_mode = 1;
        go_idle();
        enter_creds(4000, 1);
        step(1'b0, 0);
        step(1'b0, 0);
        check("to_session_in", session, 1);
`ifdef ENTRY_TIMEOUT_EN
        press(3);
        idle(TIMEOUT_CYCLES - 1);
        press(3);
        check("to_key_wins", session, 1);
        idle(TIMEOUT_CYCLES - 1);
        check("to_before_expiry", session, 1);
        idle(1);
        check("to_exit", atm_exit, 1);
        check("to_session_out", session, 0);
        press(1); press(2);
        idle(TIMEOUT_CYCLES);
        check("to_acc_abandon", digit_cnt, 0);
`else
        idle(5000);
        check("no_to_session", session, 1);
        press(12);
`endif

        // Randomized traffic
        auth_mode = 2;
        for (int it = 0; it < 40; it++) begin
            int nd;
            go_idle();
            nd = ($urandom_range(0, 9) < 7) ? 4 : int'($urandom_range(2, 5));
            for (int d = 0; d < nd; d++) begin
                press((d == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 9)));
                idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 9) == 0) press(10);
            press(11);
            if ($urandom_range(0, 9) != 0) press(int'($urandom_range(0, 9)));
            if ($urandom_range(0, 4) == 0) press(int'($urandom_range(0, 10)));
            press(11);
            noise(3);
            noise($urandom_range(0, 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
